// File: rtl/serial_transmit_pkg.sv
// Shared line-level constants and FSM state type for the serial transmitter.
package serial_transmit_pkg;

  localparam int WORD_W     = 8;
  localparam int FRAME_BITS = 10;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/serial_transmit_tx_fifo.sv
// Synchronous FIFO; full/empty come from the occupancy count, and a push is refused
// when full even if a pop happens in the same cycle.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dat     = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the cleared count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_dat;
  end

endmodule

// File: rtl/serial_transmit.sv
// Serial transmitter: start 0, 8 data bits MSB first, stop 0, idle 1; words queue in a FIFO
// and frames run back-to-back. txd is registered from the next state so it lines up with busy.
module serial_transmit
  import serial_transmit_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [WORD_W-1:0]                 data,
  input  logic                              data_valid,
  output logic                              data_ready,
  output logic                              txd,
  output logic                              busy,
  output logic                              frame_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int              CYC_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_BIT - 1);
  localparam int              DATA_BITS = FRAME_BITS - 2;
  localparam logic [2:0]      BIT_LAST  = 3'(DATA_BITS - 1);

  tx_state_t          r_state;
  logic [WORD_W-1:0]  r_shift;
  logic [2:0]         r_bit_cnt;
  logic [CYC_W-1:0]   r_cyc_cnt;
  logic               r_txd;

  tx_state_t          w_state_nxt;
  logic [WORD_W-1:0]  w_shift_nxt;
  logic [2:0]         w_bit_nxt;
  logic [CYC_W-1:0]   w_cyc_nxt;
  logic               w_txd_nxt;
  logic               w_cyc_end;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [WORD_W-1:0]  w_fifo_dat;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (data_valid),
    .i_dat   (data),
    .i_pop   (w_pop),
    .o_dat   (w_fifo_dat),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  assign w_cyc_end  = (r_cyc_cnt == CYC_LAST);
  assign data_ready = !w_full;
  assign txd        = r_txd;
  assign busy       = (r_state != IDLE);
  assign frame_done = (r_state == STOP) && w_cyc_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_cyc_cnt <= '0;
      r_txd     <= LINE_IDLE;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_cyc_cnt <= w_cyc_nxt;
      r_txd     <= w_txd_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit_cnt;
    w_cyc_nxt   = w_cyc_end ? '0 : r_cyc_cnt + CYC_W'(1);
    w_pop       = 1'b0;

    case (r_state)
      IDLE: begin
        w_cyc_nxt = '0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_dat;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_cyc_end) begin
          w_state_nxt = DATA;
          w_bit_nxt   = '0;
        end
      end
      DATA: begin
        if (w_cyc_end) begin
          if (r_bit_cnt == BIT_LAST) begin
            w_state_nxt = STOP;
          end else begin
            w_shift_nxt = {r_shift[WORD_W-2:0], 1'b0};
            w_bit_nxt   = r_bit_cnt + 3'd1;
          end
        end
      end
      STOP: begin
        // A queued word starts its start bit right after this stop bit, with no idle gap.
        if (w_cyc_end) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_fifo_dat;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    case (w_state_nxt)
      START:   w_txd_nxt = LINE_START;
      DATA:    w_txd_nxt = w_shift_nxt[WORD_W-1];
      STOP:    w_txd_nxt = LINE_STOP;
      default: w_txd_nxt = LINE_IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_transmit.sv
// Bench for serial_transmit: a line decoder pops a word scoreboard per frame; table vectors
// and hand sequences check waveform timing, FIFO limits, bit stretching and mid-frame reset.
module tb_serial_transmit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;
  logic       txd;
  logic       busy;
  logic       frame_done;
  logic [2:0] fifo_count;

  logic [7:0] data3;
  logic       valid3;
  logic       ready3;
  logic       txd3;
  logic       busy3;
  logic       fd3;
  logic [2:0] count3;

  always #5 clk = ~clk;

  serial_transmit #(.FIFO_DEPTH(4), .CLKS_PER_BIT(1)) dut (
    .clk(clk), .rst(rst), .data(data), .data_valid(data_valid), .data_ready(data_ready),
    .txd(txd), .busy(busy), .frame_done(frame_done), .fifo_count(fifo_count)
  );

  serial_transmit #(.FIFO_DEPTH(4), .CLKS_PER_BIT(3)) dut3 (
    .clk(clk), .rst(rst), .data(data3), .data_valid(valid3), .data_ready(ready3),
    .txd(txd3), .busy(busy3), .frame_done(fd3), .fifo_count(count3)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic [7:0] dat;
    logic [9:0] wave;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line decoder for the CLKS_PER_BIT=1 instance, one sample per falling edge.
  int         mstate = 0;
  int         nbit = 0;
  int         frames = 0;
  int         fd_seen = 0;
  logic [7:0] mword = '0;

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      mstate = 0;
    end else begin
      case (mstate)
        0: if (txd === 1'b0) begin mstate = 1; nbit = 0; end
        1: begin
          mword = {mword[6:0], txd};
          nbit++;
          if (nbit == 8) mstate = 2;
        end
        2: begin
          check("stop_bit", 32'(txd), 32'(0));
          check("stop_frame_done", 32'(frame_done), 32'(1));
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_underflow: got frame 0x%0h, expected no frame", mword);
          end else begin
            check("frame_word", 32'(mword), 32'(sb.pop_front()));
          end
          frames++;
          mstate = 3;
        end
        default: if (txd === 1'b0) begin mstate = 1; nbit = 0; end else mstate = 0;
      endcase
    end
    if (rst === 1'b1 && frame_done === 1'b1) fd_seen++;
  end

  task automatic push_word(input logic [7:0] w);
    int t;
    t = 0;
    @(negedge clk);
    data = w;
    data_valid = 1'b1;
    while (!data_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!data_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_timeout: data_ready stayed 0, expected 1 within 100 cycles");
    end else begin
      sb.push_back(w);
    end
    @(posedge clk);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while ((busy || fifo_count != 0) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: busy=%0b count=%0d, expected idle", busy, fifo_count);
    end
  endtask

  task automatic apply_vec(input vec_t v);
    wait_idle();
    push_word(v.dat);
    @(negedge clk);
    data_valid = 1'b0;
    check("count_before_pop", 32'(fifo_count), 32'(1));
    check("idle_before_pop", 32'(txd), 32'(1));
    for (int i = 9; i >= 0; i--) begin
      @(negedge clk);
      check($sformatf("wave_%0h_bit%0d", v.dat, i), 32'(txd), 32'(v.wave[i]));
      check($sformatf("done_%0h_bit%0d", v.dat, i), 32'(frame_done), 32'(i == 0));
    end
    @(negedge clk);
    check("idle_after_frame", 32'(txd), 32'(1));
    check("busy_after_frame", 32'(busy), 32'(0));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] bb_exp;
    logic [19:0] bb_got;
    logic [9:0]  w3;
    int          busy_lo;
    int          f0;
    int          d0;
    int          waited;
    int          bad3;
    int          fdbad3;
    int          badrst;

    vecs[0] = '{dat: 8'hA5, wave: 10'b0_10100101_0};
    vecs[1] = '{dat: 8'h00, wave: 10'b0_00000000_0};
    vecs[2] = '{dat: 8'hFF, wave: 10'b0_11111111_0};
    vecs[3] = '{dat: 8'h3C, wave: 10'b0_00111100_0};
    vecs[4] = '{dat: 8'h81, wave: 10'b0_10000001_0};

    rst = 1'b0;
    data = '0;
    data_valid = 1'b0;
    data3 = '0;
    valid3 = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(frame_done), 32'(0));
    check("rst_count", 32'(fifo_count), 32'(0));
    check("rst_ready", 32'(data_ready), 32'(1));
    check("rst_txd3", 32'(txd3), 32'(1));
    #2 rst = 1'b1;

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Back-to-back: 20 contiguous frame cycles, busy held high.
    wait_idle();
    d0 = fd_seen;
    bb_exp = 20'b0_00111100_0_0_11000011_0;
    bb_got = '0;
    busy_lo = 0;
    push_word(8'h3C);
    push_word(8'hC3);
    @(negedge clk);
    data_valid = 1'b0;
    for (int i = 19; i >= 0; i--) begin
      bb_got = {bb_got[18:0], txd};
      if (!busy) busy_lo++;
      if (i > 0) @(negedge clk);
    end
    check("b2b_wave", 32'(bb_got), 32'(bb_exp));
    check("b2b_busy_low_cycles", 32'(busy_lo), 32'(0));
    @(negedge clk);
    check("b2b_idle_after", 32'(txd), 32'(1));
    check("b2b_done_pulses", 32'(fd_seen - d0), 32'(2));

    // FIFO full: 0x01..0x05 fill it while 0x01 sends; 0x06 waits for the next pop.
    wait_idle();
    f0 = frames;
    for (int w = 1; w <= 5; w++) push_word(8'(w));
    @(negedge clk);
    data = 8'h06;
    check("full_count", 32'(fifo_count), 32'(4));
    check("full_ready", 32'(data_ready), 32'(0));
    waited = 0;
    while (!data_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("full_hold_cycles", 32'(waited), 32'(7));
    check("full_pop_no_write_through", 32'(fifo_count), 32'(3));
    sb.push_back(8'h06);
    @(posedge clk);
    @(negedge clk);
    data_valid = 1'b0;
    check("full_refill_count", 32'(fifo_count), 32'(4));
    wait_idle();
    check("full_frames", 32'(frames - f0), 32'(6));

    // Bit stretching on the CLKS_PER_BIT=3 instance.
    w3 = 10'b0_10000000_0;
    bad3 = 0;
    fdbad3 = 0;
    @(negedge clk);
    data3 = 8'h80;
    valid3 = 1'b1;
    @(negedge clk);
    valid3 = 1'b0;
    check("cpb3_count_before_pop", 32'(count3), 32'(1));
    check("cpb3_idle_before_pop", 32'(txd3), 32'(1));
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (txd3 !== w3[9 - c / 3]) bad3++;
      if (fd3 !== (c == 29)) fdbad3++;
      if (c == 4) check("cpb3_msb_mid", 32'(txd3), 32'(1));
    end
    check("cpb3_wave_errors", 32'(bad3), 32'(0));
    check("cpb3_done_errors", 32'(fdbad3), 32'(0));
    @(negedge clk);
    check("cpb3_idle_after", 32'(txd3), 32'(1));
    check("cpb3_busy_after", 32'(busy3), 32'(0));

    // Reset in the 4th data bit of 0xFF with a second word queued.
    wait_idle();
    push_word(8'hFF);
    push_word(8'h12);
    @(negedge clk);
    data_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_txd", 32'(txd), 32'(1));
    check("pre_rst_busy", 32'(busy), 32'(1));
    check("pre_rst_count", 32'(fifo_count), 32'(1));
    #2 rst = 1'b0;
    sb.delete();
    #1;
    check("midrst_txd", 32'(txd), 32'(1));
    check("midrst_count", 32'(fifo_count), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_ready", 32'(data_ready), 32'(1));
    data = 8'h77;
    data_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    data_valid = 1'b0;
    #2 rst = 1'b1;
    badrst = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) badrst++;
    end
    check("post_rst_quiet_cycles", 32'(badrst), 32'(0));
    check("post_rst_count", 32'(fifo_count), 32'(0));
    apply_vec(vecs[0]);

    // Decoded loopback of three frames.
    wait_idle();
    f0 = frames;
    d0 = fd_seen;
    push_word(8'h5A);
    push_word(8'hFF);
    push_word(8'h00);
    @(negedge clk);
    data_valid = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    check("loop_frames", 32'(frames - f0), 32'(3));
    check("loop_done_pulses", 32'(fd_seen - d0), 32'(3));
    check("sb_drained", 32'(sb.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
